pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Generic, parametrised pipeline stage register that replaces the fixed per-stage registers (IF/ID … MEM/WB) with one reusable block.
- Carries an opaque datapath payload and a control payload with a valid/ready elastic handshake, synchronous flush, and forced-zero control on bubbles.
- Sits between any two pipeline stages; the hazard unit drives flush and downstream ready (stall).

Parameters:
- DATA_W, 101, datapath payload width (default: alu_result 32 + read_data 32 + pc_plus4 32 + reg_dest 5).
- CTRL_W, 3, control payload width (default: reg_write 1 + result_src 2).
- CTRL_BUBBLE, '0, control value presented whenever out_valid=0 (bubble encoding).

Ports:
- clk  in  1  clock, all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream stage holds a valid instruction.
- in_ready  out  1  stage accepts in_* this cycle.
- in_data  in  DATA_W  upstream datapath payload.
- in_ctrl  in  CTRL_W  upstream control payload.
- out_valid  out  1  downstream payload valid.
- out_ready  in  1  downstream accepts (0 = stall).
- out_data  out  DATA_W  registered datapath payload.
- out_ctrl  out  CTRL_W  registered control payload; CTRL_BUBBLE when out_valid=0.

Behaviour:
- Reset (sync, reset=1 at posedge): out_valid=0, out_data=0, out_ctrl=CTRL_BUBBLE, in_ready=1 (base) / 1 (skid), all internal valid bits 0. Reset has priority over flush and handshakes.
- Transfer in: in_valid & in_ready at posedge. Transfer out: out_valid & out_ready at posedge.
- Latency: 1 cycle in_* → out_* when not stalled. Throughput: 1 per cycle while out_ready=1.
- Base mode (macro off): single entry. in_ready = out_ready | ~out_valid (combinational). On a transfer in, the entry loads in_data/in_ctrl and sets valid. On a transfer out without a transfer in, valid clears. Stall (out_ready=0, out_valid=1) holds out_data/out_ctrl bit-exact.
- Bubble rule: out_ctrl is forced to CTRL_BUBBLE whenever out_valid=0. out_data keeps its last value (don't-care to consumers, but must not be X after reset).
- Flush: at posedge with flush=1, all valid bits clear and any same-cycle in_valid is dropped. in_ready may read 1 during flush; no data is captured. flush=1 with out_ready=0 still clears the entry.
- Simultaneous in and out transfer on a full entry: the entry replaces its contents, valid stays 1, and no cycle is lost.
- in_data/in_ctrl are sampled only on a transfer in; they are ignored otherwise.

Optional Feature:
- Macro: PIPE_STAGE_SKID_EN.
- Defined: two-entry skid buffer. in_ready is registered (= ~skid_valid) and has no combinational path from out_ready. When out_ready drops while an input is accepted, the word parks in the skid entry. The skid entry drains to the main entry first, preserving order. Full throughput is retained.
- Defined, skid full (skid_valid=1): in_ready=0 on the next cycle. Flush clears both entries.
- Undefined: base single-entry behaviour above. No skid storage is synthesised.

Decomposition:
- Shared package pipe_pkg holds:
  - localparams: MEM_WB_DATA_W=101, MEM_WB_CTRL_W=3, EX_MEM_*, etc.
  - packed struct typedefs per stage: mem_wb_data_t {alu_result, read_data, reg_dest, pc_plus4}; mem_wb_ctrl_t {reg_write, result_src[1:0]}.
  - result_src encoding enum.
- Instantiating stages cast structs to in_data/in_ctrl.
- One natural sub-module, pipe_skid_buf (skid entry plus order mux), instantiated only under PIPE_STAGE_SKID_EN.

Test Plan:
- Reset: assert reset=1 for 2 cycles with in_valid=1 → out_valid=0, out_ctrl=3'b000, out_data=0; in_ready=1 after release.
- Streaming: out_ready=1; send data 0x1..0x5 with ctrl=3'b101 on 5 back-to-back cycles → same 5 words on out_* one cycle later each, no gaps, in order.
- Stall: word A=0xAAAA_0001 valid, out_ready=0 for 3 cycles → out_data holds A unchanged. Base mode: in_ready=0 for those cycles. Skid mode: exactly one extra word B is accepted, then in_ready=0. Release → A then B emitted.
- Flush: A held under stall, flush=1 with in_valid=1 (word C) → next cycle out_valid=0, out_ctrl=0, C never appears.
- Bubble control: in_valid=0 with in_ctrl=3'b111 driven → out_ctrl stays 3'b000, so reg_write is never seen high on a bubble.
- Simultaneous: full entry, in and out transfer in the same cycle, repeated 10 cycles with random out_ready → scoreboard shows no loss, no duplication, order preserved, for both macro settings.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline-stage types: per-stage payload structs, widths and the
// result_src encoding. Stages cast these structs onto pipe_stage_reg ports.
package pipe_pkg;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] write_data;
        logic [4:0]  reg_dest;
        logic [31:0] pc_plus4;
    } ex_mem_data_t;

    typedef struct packed {
        logic        reg_write;
        result_src_e result_src;
        logic        mem_write;
    } ex_mem_ctrl_t;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] read_data;
        logic [4:0]  reg_dest;
        logic [31:0] pc_plus4;
    } mem_wb_data_t;

    typedef struct packed {
        logic        reg_write;
        result_src_e result_src;
    } mem_wb_ctrl_t;

    localparam int EX_MEM_DATA_W = $bits(ex_mem_data_t);
    localparam int EX_MEM_CTRL_W = $bits(ex_mem_ctrl_t);
    localparam int MEM_WB_DATA_W = $bits(mem_wb_data_t);
    localparam int MEM_WB_CTRL_W = $bits(mem_wb_ctrl_t);

    function automatic logic wb_writes_reg(input mem_wb_ctrl_t ctrl);
        return ctrl.reg_write;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Skid entry for pipe_stage_reg: parks one word while the main entry is
// stalled and presents the oldest word (skid first) to the main entry.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int DATA_W = MEM_WB_DATA_W,
    parameter int CTRL_W = MEM_WB_CTRL_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              in_ready,
    input  logic              main_free,
    output logic              src_valid,
    output logic [DATA_W-1:0] src_data,
    output logic [CTRL_W-1:0] src_ctrl
);

    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic              accept;

    // in_ready comes straight from a flop, so out_ready never reaches it
    assign in_ready  = ~skid_valid_q;
    assign accept    = in_valid & ~skid_valid_q;

    assign src_valid = skid_valid_q | accept;
    assign src_data  = skid_valid_q ? skid_data_q : in_data;
    assign src_ctrl  = skid_valid_q ? skid_ctrl_q : in_ctrl;

    always_comb begin
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_ctrl_d  = skid_ctrl_q;
        if (flush) begin
            skid_valid_d = 1'b0;
        end else if (skid_valid_q && main_free) begin
            skid_valid_d = 1'b0;
        end else if (accept && !main_free) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
            skid_ctrl_d  = in_ctrl;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_ctrl_q  <= '0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_ctrl_q  <= skid_ctrl_d;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Reusable elastic pipeline stage register with flush and bubble control.
// Define PIPE_STAGE_SKID_EN for a two-entry skid version with registered in_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int              DATA_W      = MEM_WB_DATA_W,
    parameter int              CTRL_W      = MEM_WB_CTRL_W,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              main_free;
    logic              src_valid;
    logic [DATA_W-1:0] src_data;
    logic [CTRL_W-1:0] src_ctrl;

    assign main_free = ~valid_q | out_ready;

`ifdef PIPE_STAGE_SKID_EN
    pipe_skid_buf #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .in_ready  (in_ready),
        .main_free (main_free),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_ctrl  (src_ctrl)
    );
`else
    assign in_ready  = main_free;
    assign src_valid = in_valid & main_free;
    assign src_data  = in_data;
    assign src_ctrl  = in_ctrl;
`endif

    // Load whenever the entry is free or leaving; otherwise a departing word empties it
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (main_free && src_valid) begin
            valid_d = 1'b1;
            data_d  = src_data;
            ctrl_d  = src_ctrl;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= CTRL_BUBBLE;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_ctrl  = valid_q ? ctrl_q : CTRL_BUBBLE;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg against a queue-based FIFO model
// (capacity 1, or 2 when PIPE_STAGE_SKID_EN is defined).
module tb_pipe_stage_reg;

    localparam int DATA_W = 101;
    localparam int CTRL_W = 3;
    localparam int WORD_W = DATA_W + CTRL_W;
`ifdef PIPE_STAGE_SKID_EN
    localparam int CAPACITY = 2;
`else
    localparam int CAPACITY = 1;
`endif

    logic              clk;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;

    int n_cmp;
    int n_err;

    logic [WORD_W-1:0] mq[$];

    pipe_stage_reg #(
        .DATA_W      (DATA_W),
        .CTRL_W      (CTRL_W),
        .CTRL_BUBBLE (3'b000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // A stage is an elastic FIFO: base mode may take a word only if empty or
    // draining this cycle; skid mode only looks at its own occupancy.
    function automatic logic model_in_ready();
        if (CAPACITY == 2) return mq.size() < 2;
        return (mq.size() == 0) || out_ready;
    endfunction

    function automatic logic [DATA_W-1:0] rand_data();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[DATA_W-1:0];
    endfunction

    task automatic tick();
        logic rdy, pop, push;
        logic [WORD_W-1:0] w;
        rdy  = model_in_ready();
        pop  = (mq.size() > 0) && out_ready;
        push = in_valid && rdy;
        w    = {in_ctrl, in_data};
        @(posedge clk);
        if (reset || flush) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(w);
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        in_data = rand_data(); in_ctrl = 3'b111;
        tick();
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("[TB] FAIL reset_valid: got %b want 0", out_valid);
        end
        n_cmp++;
        if (out_ctrl !== 3'b000) begin
            n_err++; $display("[TB] FAIL reset_ctrl: got %b want 000", out_ctrl);
        end
        n_cmp++;
        if (out_data !== {DATA_W{1'b0}}) begin
            n_err++; $display("[TB] FAIL reset_data: got %h want 0", out_data);
        end
        reset = 1'b0; in_valid = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        in_ctrl   = 3'b101;
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'(i);
            #1;
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_err++; $display("[TB] FAIL stream_in_ready[%0d]: got %b want 1", i, in_ready);
            end
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== DATA_W'(i) || out_ctrl !== 3'b101) begin
                n_err++;
                $display("[TB] FAIL stream_word[%0d]: got v=%b d=%h c=%b want v=1 d=%h c=101",
                         i, out_valid, out_data, out_ctrl, DATA_W'(i));
            end
        end
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || out_ctrl !== 3'b000) begin
            n_err++; $display("[TB] FAIL stream_drain: got v=%b c=%b want v=0 c=000", out_valid, out_ctrl);
        end
    endtask

    task automatic test_stall();
        logic [DATA_W-1:0] a, b;
        int accepted;
        a = DATA_W'(32'hAAAA_0001);
        b = DATA_W'(32'hBBBB_0002);
        out_ready = 1'b1; in_valid = 1'b1; in_data = a; in_ctrl = 3'b001;
        tick();
        in_data = b; in_ctrl = 3'b010; out_ready = 1'b0;
        accepted = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++;
            if (in_ready !== model_in_ready()) begin
                n_err++; $display("[TB] FAIL stall_in_ready[%0d]: got %b want %b", c, in_ready, model_in_ready());
            end
            if (in_ready) accepted++;
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== a || out_ctrl !== 3'b001) begin
                n_err++;
                $display("[TB] FAIL stall_hold[%0d]: got v=%b d=%h c=%b want v=1 d=%h c=001",
                         c, out_valid, out_data, out_ctrl, a);
            end
        end
        n_cmp++;
        if (accepted !== CAPACITY - 1) begin
            n_err++; $display("[TB] FAIL stall_extra_accept: got %0d want %0d", accepted, CAPACITY - 1);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_cmp++;
            if (out_valid !== (mq.size() > 0)) begin
                n_err++; $display("[TB] FAIL release_valid[%0d]: got %b want %b", c, out_valid, mq.size() > 0);
            end else if (mq.size() > 0 && (out_data !== b || out_ctrl !== 3'b010)) begin
                n_err++; $display("[TB] FAIL release_b[%0d]: got d=%h c=%b want d=%h c=010", c, out_data, out_ctrl, b);
            end
        end
    endtask

    task automatic test_flush();
        logic [DATA_W-1:0] a, c;
        a = rand_data();
        c = DATA_W'(32'hCCCC_0003);
        out_ready = 1'b1; in_valid = 1'b1; in_data = a; in_ctrl = 3'b111;
        tick();
        out_ready = 1'b0; in_valid = 1'b0;
        tick();
        flush = 1'b1; in_valid = 1'b1; in_data = c; in_ctrl = 3'b011;
        tick();
        flush = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || out_ctrl !== 3'b000) begin
            n_err++; $display("[TB] FAIL flush_clear: got v=%b c=%b want v=0 c=000", out_valid, out_ctrl);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_err++; $display("[TB] FAIL flush_no_c[%0d]: got v=%b d=%h want v=0", k, out_valid, out_data);
            end
        end
    endtask

    task automatic test_bubble();
        in_valid = 1'b0; in_ctrl = 3'b111;
        for (int k = 0; k < 4; k++) begin
            in_data   = rand_data();
            out_ready = 1'($urandom_range(0, 1));
            tick();
            n_cmp++;
            if (out_valid !== 1'b0 || out_ctrl !== 3'b000) begin
                n_err++; $display("[TB] FAIL bubble_ctrl[%0d]: got v=%b c=%b want v=0 c=000", k, out_valid, out_ctrl);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic exp_rdy;
        for (int k = 0; k < 300; k++) begin
            in_valid  = (k < 12) ? 1'b1 : ($urandom_range(0, 3) != 0);
            out_ready = (k < 2) ? 1'b0 : 1'($urandom_range(0, 1));
            flush     = (k > 40) && ($urandom_range(0, 31) == 0);
            in_data   = rand_data();
            in_ctrl   = 3'($urandom_range(0, 7));
            #1;
            exp_rdy = model_in_ready();
            n_cmp++;
            if (in_ready !== exp_rdy) begin
                n_err++; $display("[TB] FAIL b2b_in_ready[%0d]: got %b want %b", k, in_ready, exp_rdy);
            end
            tick();
            n_cmp++;
            if (out_valid !== (mq.size() > 0)) begin
                n_err++; $display("[TB] FAIL b2b_valid[%0d]: got %b want %b", k, out_valid, mq.size() > 0);
            end else if (mq.size() > 0) begin
                n_cmp++;
                if ({out_ctrl, out_data} !== mq[0]) begin
                    n_err++; $display("[TB] FAIL b2b_word[%0d]: got %h want %h", k, {out_ctrl, out_data}, mq[0]);
                end
            end else begin
                n_cmp++;
                if (out_ctrl !== 3'b000) begin
                    n_err++; $display("[TB] FAIL b2b_bubble[%0d]: got %b want 000", k, out_ctrl);
                end
            end
        end
        flush = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_ctrl = '0;
        #2;
        test_reset();
        test_streaming();
        test_stall();
        test_flush();
        test_bubble();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
